// File: rtl/fifo_sram_pkg.sv
// Shared constants, types and helpers for the packet FIFO and the processor
// tie-in that shares its RAM.
package fifo_sram_pkg;

  // Width of the ctrl byte carried in the top bits of each data word.
  localparam int CTRL_W = 8;

  // Write-side packet state: accepting words, or dropping the rest of a
  // packet that overflowed.
  typedef enum logic {
    WR_ACCEPT = 1'b0,
    WR_DROP   = 1'b1
  } wr_state_e;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

  // Bit positions of the ctrl byte inside a data word of width dw.
  function automatic int ctrl_lsb(input int dw);
    return dw - CTRL_W;
  endfunction

  function automatic int ctrl_msb(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/fifo_sram_pkt_if.sv
// Bus bundle for the packet FIFO: write side, read side, processor RAM ports
// and status. The master drives requests, the slave (FIFO) answers.
//
// Handshakes:
//   write: a word is offered on every cycle wr_en is high. It is stored only
//          when wr_ready is high; a word offered while wr_ready is low poisons
//          the packet, which is then dropped at its wr_eop. wr_eop qualifies
//          wr_en and commits the packet in that cycle.
//   read:  rd_en is a pop request, honoured only when empty is low. The popped
//          word appears on rd_data in the next cycle with rd_valid high;
//          rd_valid is a one-cycle strobe with no backpressure.
interface fifo_sram_pkt_if #(
  parameter int DWIDTH = 72,
  parameter int AWIDTH = 8,
  parameter int OWIDTH = 16
) ();
  import fifo_sram_pkg::*;

  logic              proc_mode;
  logic              wr_en;
  logic [DWIDTH-1:0] wr_data;
  logic              wr_eop;
  logic              wr_abort;
  logic              wr_ready;
  logic              rd_en;
  logic [DWIDTH-1:0] rd_data;
  logic              rd_valid;
  logic              flush;
  logic              proc_wea;
  logic [AWIDTH-1:0] proc_addra;
  logic [DWIDTH-1:0] proc_dina;
  logic [DWIDTH-1:0] proc_douta;
  logic [AWIDTH-1:0] proc_addrb;
  logic [DWIDTH-1:0] proc_doutb;
  logic [AWIDTH:0]   level;
  logic              empty;
  logic              almfull;
  logic [OWIDTH-1:0] ovf_cnt;
  wr_state_e         wr_state_dbg;

  modport master (
    output proc_mode, wr_en, wr_data, wr_eop, wr_abort, rd_en, flush,
           proc_wea, proc_addra, proc_dina, proc_addrb,
    input  wr_ready, rd_data, rd_valid, proc_douta, proc_doutb,
           level, empty, almfull, ovf_cnt, wr_state_dbg
  );

  modport slave (
    input  proc_mode, wr_en, wr_data, wr_eop, wr_abort, rd_en, flush,
           proc_wea, proc_addra, proc_dina, proc_addrb,
    output wr_ready, rd_data, rd_valid, proc_douta, proc_doutb,
           level, empty, almfull, ovf_cnt, wr_state_dbg
  );

endinterface

// File: rtl/sram_dp_rf.sv
// Dual-port read-first RAM, single clock. Port A reads and writes, port B
// only reads (nothing in this design writes through B). Both outputs are
// registered, one cycle after the address.
module sram_dp_rf #(
  parameter int DWIDTH = 72,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              wea,
  input  logic [AWIDTH-1:0] addra,
  input  logic [DWIDTH-1:0] dina,
  output logic [DWIDTH-1:0] douta,
  input  logic [AWIDTH-1:0] addrb,
  output logic [DWIDTH-1:0] doutb
);

  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  // Port A: read the old contents, then write (read-first).
  always_ff @(posedge clk) begin
    douta <= mem[addra];
    if (wea) begin
      mem[addra] <= dina;
    end
  end

  // Port B: read only.
  always_ff @(posedge clk) begin
    doutb <= mem[addrb];
  end

endmodule

// File: rtl/fifo_sram_pkt.sv
// Packet FIFO over one dual-port RAM. Packets become readable only once their
// last word is written; a poisoned or aborted packet rewinds the write
// pointer to the committed tail. In processor mode the RAM ports belong to
// the processor and every FIFO pointer holds.
module fifo_sram_pkt
  import fifo_sram_pkg::*;
#(
  parameter int DWIDTH   = 72,
  parameter int AWIDTH   = 8,
  parameter int ALM_FULL = 240,
  parameter int OWIDTH   = 16
) (
  input logic           clk,
  input logic           reset_n,
  fifo_sram_pkt_if.slave bus
);

  localparam int            PW      = ptr_w(AWIDTH);
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [PW-1:0] ALM_P   = PW'(ALM_FULL);

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  wr_state_e         wr_state_q, wr_state_d;
  logic [OWIDTH-1:0] ovf_q, ovf_d;
  logic              rd_valid_q, rd_valid_d;

  logic [PW-1:0]     used;
  logic [PW-1:0]     level_w;
  logic              full;
  logic              is_empty;
  logic              wr_accept;

  logic              ram_wea;
  logic [AWIDTH-1:0] ram_addra;
  logic [AWIDTH-1:0] ram_addrb;
  logic [DWIDTH-1:0] ram_dina;
  logic [DWIDTH-1:0] ram_douta;
  logic [DWIDTH-1:0] ram_doutb;

  // used counts uncommitted words too; level counts only committed ones.
  assign used     = wr_ptr_q - head_q;
  assign level_w  = tail_q - head_q;
  assign full     = (used == DEPTH_P);
  assign is_empty = (level_w == '0);

  // State register for pointers, write-side packet state and counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      wr_ptr_q   <= '0;
      wr_state_q <= WR_ACCEPT;
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_state_q <= wr_state_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next-state: read/flush on the head side, write/commit/drop on the tail
  // side. Flush uses the tail from before this cycle, so a packet committed
  // in the same cycle survives it.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    wr_ptr_d   = wr_ptr_q;
    wr_state_d = wr_state_q;
    ovf_d      = ovf_q;
    rd_valid_d = 1'b0;
    wr_accept  = 1'b0;
    if (!bus.proc_mode) begin
      if (bus.flush) begin
        head_d = tail_q;
      end else if (bus.rd_en && !is_empty) begin
        head_d     = head_q + 1'b1;
        rd_valid_d = 1'b1;
      end

      if (bus.wr_abort) begin
        wr_ptr_d   = tail_q;
        wr_state_d = WR_ACCEPT;
      end else if (bus.wr_en) begin
        case (wr_state_q)
          WR_ACCEPT: begin
            if (full) begin
              if (bus.wr_eop) begin
                wr_ptr_d = tail_q;
                if (ovf_q != '1) ovf_d = ovf_q + 1'b1;
              end else begin
                wr_state_d = WR_DROP;
              end
            end else begin
              wr_accept = 1'b1;
              wr_ptr_d  = wr_ptr_q + 1'b1;
              if (bus.wr_eop) tail_d = wr_ptr_q + 1'b1;
            end
          end
          WR_DROP: begin
            if (bus.wr_eop) begin
              wr_ptr_d   = tail_q;
              wr_state_d = WR_ACCEPT;
              if (ovf_q != '1) ovf_d = ovf_q + 1'b1;
            end
          end
          default: wr_state_d = WR_ACCEPT;
        endcase
      end
    end
  end

  // RAM port ownership: FIFO writes on A and reads the head on B, unless the
  // processor owns both ports.
  always_comb begin
    if (bus.proc_mode) begin
      ram_wea   = bus.proc_wea;
      ram_addra = bus.proc_addra;
      ram_dina  = bus.proc_dina;
      ram_addrb = bus.proc_addrb;
    end else begin
      ram_wea   = wr_accept;
      ram_addra = wr_ptr_q[AWIDTH-1:0];
      ram_dina  = bus.wr_data;
      ram_addrb = head_q[AWIDTH-1:0];
    end
  end

  sram_dp_rf #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk   (clk),
    .wea   (ram_wea),
    .addra (ram_addra),
    .dina  (ram_dina),
    .douta (ram_douta),
    .addrb (ram_addrb),
    .doutb (ram_doutb)
  );

  assign bus.wr_ready     = !full && !bus.proc_mode;
  assign bus.rd_data      = ram_doutb;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.proc_douta   = ram_douta;
  assign bus.proc_doutb   = ram_doutb;
  assign bus.level        = level_w;
  assign bus.empty        = is_empty;
  assign bus.almfull      = (used > ALM_P);
  assign bus.ovf_cnt      = ovf_q;
  assign bus.wr_state_dbg = wr_state_q;

endmodule

// File: tb/tb_fifo_sram_pkt.sv
// Bench for fifo_sram_pkt at DEPTH = 16: directed packet scenarios plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_fifo_sram_pkt;
  import fifo_sram_pkg::*;

  localparam int DW    = 72;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int ALMF  = 14;
  localparam int OW    = 16;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fifo_sram_pkt_if #(.DWIDTH(DW), .AWIDTH(AW), .OWIDTH(OW)) bus ();

  fifo_sram_pkt #(
    .DWIDTH   (DW),
    .AWIDTH   (AW),
    .ALM_FULL (ALMF),
    .OWIDTH   (OW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds committed unread words in read order, pend_q the packet
  // being written. Occupancy for full/almfull is the sum of both.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pend_q[$];
  bit            m_bad = 1'b0;
  int            m_ovf = 0;
  bit            m_rv  = 1'b0;
  logic [DW-1:0] m_rd;

  always @(posedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      pend_q.delete();
      m_bad = 1'b0;
      m_ovf = 0;
      m_rv  = 1'b0;
    end else if (bus.proc_mode) begin
      m_rv = 1'b0;
    end else begin
      int occ;
      bit m_full;
      occ    = exp_q.size() + pend_q.size();
      m_full = (occ == DEPTH);
      m_rv   = 1'b0;
      if (bus.flush) begin
        exp_q.delete();
      end else if (bus.rd_en && exp_q.size() != 0) begin
        m_rd = exp_q.pop_front();
        m_rv = 1'b1;
      end
      if (bus.wr_abort) begin
        pend_q.delete();
        m_bad = 1'b0;
      end else if (bus.wr_en) begin
        if (m_bad || m_full) begin
          if (bus.wr_eop) begin
            pend_q.delete();
            m_bad = 1'b0;
            if (m_ovf < (1 << OW) - 1) m_ovf++;
          end else begin
            m_bad = 1'b1;
          end
        end else begin
          pend_q.push_back(bus.wr_data);
          if (bus.wr_eop) begin
            foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
            pend_q.delete();
          end
        end
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      int occ;
      occ = exp_q.size() + pend_q.size();
      chk("level",     DW'(bus.level),    DW'(exp_q.size()));
      chk("empty",     DW'(bus.empty),    DW'(exp_q.size() == 0));
      chk("almfull",   DW'(bus.almfull),  DW'(occ > ALMF));
      chk("wr_ready",  DW'(bus.wr_ready), DW'(occ != DEPTH && !bus.proc_mode));
      chk("ovf_cnt",   DW'(bus.ovf_cnt),  DW'(m_ovf));
      chk("rd_valid",  DW'(bus.rd_valid), DW'(m_rv));
      chk("bad_state", DW'(bus.wr_state_dbg == WR_DROP), DW'(m_bad));
      if (m_rv) chk("rd_data", bus.rd_data, m_rd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.proc_mode  = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    bus.wr_eop     = 1'b0;
    bus.wr_abort   = 1'b0;
    bus.rd_en      = 1'b0;
    bus.flush      = 1'b0;
    bus.proc_wea   = 1'b0;
    bus.proc_addra = '0;
    bus.proc_dina  = '0;
    bus.proc_addrb = '0;
  endtask

  task automatic wr(input logic [DW-1:0] d, input bit eop);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    bus.wr_eop  = eop;
    cyc();
    bus.wr_en  = 1'b0;
    bus.wr_eop = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [DW-1:0] exp);
    bus.rd_en = 1'b1;
    cyc();
    bus.rd_en = 1'b0;
    chk(nm, bus.rd_data, exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  acc;
    int  nrd;
    bit  alm_seen;
    bit  order_ok;
    int  wr_pct;
    int  rd_pct;

    idle();
    reset_n = 1'b0;
    cyc();
    cyc();
    chk_en = 1'b1;
    chk("rst_level",    DW'(bus.level),    DW'(0));
    chk("rst_empty",    DW'(bus.empty),    DW'(1));
    chk("rst_almfull",  DW'(bus.almfull),  DW'(0));
    chk("rst_wr_ready", DW'(bus.wr_ready), DW'(1));
    chk("rst_rd_valid", DW'(bus.rd_valid), DW'(0));
    chk("rst_ovf",      DW'(bus.ovf_cnt),  DW'(0));
    reset_n = 1'b1;
    cyc();

    // Basic 4-word packet.
    for (int i = 1; i <= 4; i++) begin
      wr(DW'(i), i == 4);
      if (i < 4) chk("basic_empty_pre", DW'(bus.empty), DW'(1));
    end
    chk("basic_level", DW'(bus.level), DW'(4));
    for (int i = 1; i <= 4; i++) rd("basic_rd_data", DW'(i));
    cyc();
    chk("basic_empty_post", DW'(bus.empty), DW'(1));
    chk("basic_rv_post",    DW'(bus.rd_valid), DW'(0));

    // Abort a partial packet; the word offered with the abort is lost too.
    wr(DW'(10), 1'b0);
    wr(DW'(11), 1'b0);
    wr(DW'(12), 1'b0);
    bus.wr_abort = 1'b1;
    wr(DW'(13), 1'b0);
    bus.wr_abort = 1'b0;
    wr(DW'(20), 1'b0);
    wr(DW'(21), 1'b1);
    chk("abort_level", DW'(bus.level), DW'(2));
    rd("abort_rd0", DW'(20));
    rd("abort_rd1", DW'(21));
    cyc();

    // Overflow: 12 committed, then an 8-word packet that only fits 4 words.
    for (int i = 0; i < 12; i++) wr(DW'(100 + i), i == 11);
    chk("ovf_level_pre", DW'(bus.level), DW'(12));
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.wr_ready) acc++;
      wr(DW'(200 + i), i == 7);
    end
    chk("ovf_accepted", DW'(acc),          DW'(4));
    chk("ovf_cnt_one",  DW'(bus.ovf_cnt),  DW'(1));
    chk("ovf_level",    DW'(bus.level),    DW'(12));
    chk("ovf_wr_ready", DW'(bus.wr_ready), DW'(1));
    chk("ovf_almfull",  DW'(bus.almfull),  DW'(0));
    rd("ovf_rd_first", DW'(100));
    bus.rd_en = 1'b1;
    repeat (12) cyc();
    bus.rd_en = 1'b0;
    cyc();
    chk("ovf_drained", DW'(bus.empty), DW'(1));
    wr(DW'(300), 1'b1);
    rd("ovf_rewound", DW'(300));
    cyc();

    // Wrap-around: 40 single-word packets with continuous reads.
    nrd      = 0;
    alm_seen = 1'b0;
    order_ok = 1'b1;
    for (int i = 0; i < 44; i++) begin
      bus.rd_en = 1'b1;
      if (i < 40) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = DW'(i);
        bus.wr_eop  = 1'b1;
      end else begin
        bus.wr_en  = 1'b0;
        bus.wr_eop = 1'b0;
      end
      cyc();
      if (bus.almfull) alm_seen = 1'b1;
      if (bus.rd_valid) begin
        if (bus.rd_data !== DW'(nrd)) order_ok = 1'b0;
        nrd++;
      end
    end
    bus.rd_en = 1'b0;
    cyc();
    chk("wrap_count",   DW'(nrd),      DW'(40));
    chk("wrap_order",   DW'(order_ok), DW'(1));
    chk("wrap_almfull", DW'(alm_seen), DW'(0));

    // Flush in the same cycle as a commit: only the new packet remains.
    for (int i = 0; i < 5; i++) wr(DW'(400 + i), i == 4);
    chk("flush_level_pre", DW'(bus.level), DW'(5));
    wr(DW'(500), 1'b0);
    wr(DW'(501), 1'b0);
    bus.flush = 1'b1;
    wr(DW'(502), 1'b1);
    bus.flush = 1'b0;
    chk("flush_level", DW'(bus.level), DW'(3));
    rd("flush_rd0", DW'(500));
    rd("flush_rd1", DW'(501));
    rd("flush_rd2", DW'(502));
    cyc();

    // Reset in the middle of a packet: nothing survives, no overflow count.
    wr(DW'(600), 1'b0);
    wr(DW'(601), 1'b0);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("midrst_ovf",   DW'(bus.ovf_cnt), DW'(0));
    chk("midrst_level", DW'(bus.level),   DW'(0));

    // Processor mode: direct RAM access, FIFO requests ignored.
    wr(DW'('h51), 1'b0);
    wr(DW'('h52), 1'b0);
    wr(DW'('h53), 1'b1);
    cyc();
    bus.proc_mode = 1'b1;
    cyc();
    chk("proc_wr_ready", DW'(bus.wr_ready), DW'(0));
    bus.proc_wea   = 1'b1;
    bus.proc_addra = AW'(7);
    bus.proc_dina  = DW'('h11);
    cyc();
    bus.proc_dina = DW'('hAB);
    bus.wr_en     = 1'b1;
    bus.wr_data   = DW'('hEE);
    bus.wr_eop    = 1'b1;
    bus.rd_en     = 1'b1;
    bus.flush     = 1'b1;
    bus.wr_abort  = 1'b1;
    cyc();
    chk("proc_read_first", bus.proc_douta, DW'('h11));
    bus.proc_wea   = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_eop     = 1'b0;
    bus.rd_en      = 1'b0;
    bus.flush      = 1'b0;
    bus.wr_abort   = 1'b0;
    bus.proc_addra = AW'(1);
    bus.proc_addrb = AW'(7);
    cyc();
    chk("proc_doutb",    bus.proc_doutb, DW'('hAB));
    chk("proc_douta",    bus.proc_douta, DW'('h52));
    chk("proc_level",    DW'(bus.level),    DW'(3));
    chk("proc_rd_valid", DW'(bus.rd_valid), DW'(0));
    bus.proc_mode = 1'b0;
    cyc();
    chk("proc_level_back", DW'(bus.level), DW'(3));
    rd("proc_rd0", DW'('h51));
    rd("proc_rd1", DW'('h52));
    rd("proc_rd2", DW'('h53));
    cyc();

    // Randomized traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      if ((i / 300) % 2 == 0) begin
        wr_pct = 80;
        rd_pct = 30;
      end else begin
        wr_pct = 30;
        rd_pct = 80;
      end
      bus.wr_en    = ($urandom_range(0, 99) < wr_pct);
      bus.wr_data  = DW'({$urandom(), $urandom(), $urandom()});
      bus.wr_eop   = ($urandom_range(0, 5) == 0);
      bus.wr_abort = ($urandom_range(0, 60) == 0);
      bus.rd_en    = ($urandom_range(0, 99) < rd_pct);
      bus.flush    = ($urandom_range(0, 150) == 0);
      cyc();
    end
    idle();
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sram_pkt.md
Name: fifo_sram_pkt

Overview:
- Parametrised packet FIFO over a single inferred dual-port SRAM, for the packet path between the network input and the processor/accelerator.
- Each packet becomes visible to the reader only once its last word is written (commit), so a partially written packet is never read.
- The writer can discard a partial packet, and the reader side can flush all committed data.
- A processor mode hands both RAM ports to the processor for direct load/store and freezes all FIFO pointers.

Parameters:
- DWIDTH, 72, data word width in bits (top 8 bits carry the ctrl byte; the block does not interpret it).
- AWIDTH, 8, RAM address width; DEPTH = 2**AWIDTH words.
- ALM_FULL, 240, almfull threshold in words, counted including uncommitted words; legal range 1..DEPTH-1.
- OWIDTH, 16, width of the overflow-drop counter.

Ports:
- clk, in, 1, clock.
- reset_n, in, 1, synchronous reset, active-low.
- proc_mode, in, 1, 1 = processor owns both RAM ports; FIFO pointers frozen.
- wr_en, in, 1, write one word at the write pointer.
- wr_data, in, DWIDTH, write word.
- wr_eop, in, 1, qualifies wr_en: this word is the last word of the packet (commit).
- wr_abort, in, 1, discard the current uncommitted packet.
- wr_ready, out, 1, space available and not in processor mode.
- rd_en, in, 1, pop one committed word.
- rd_data, out, DWIDTH, popped word.
- rd_valid, out, 1, rd_data is valid this cycle.
- flush, in, 1, discard all committed, unread words.
- proc_wea, in, 1, processor write on port A.
- proc_addra, in, AWIDTH, port A address.
- proc_dina, in, DWIDTH, port A write data.
- proc_douta, out, DWIDTH, port A read data, 1-cycle latency.
- proc_addrb, in, AWIDTH, port B read address.
- proc_doutb, out, DWIDTH, port B read data, 1-cycle latency.
- level, out, AWIDTH+1, committed words available to the reader (0..DEPTH).
- empty, out, 1, level == 0.
- almfull, out, 1, (wr_ptr - head) > ALM_FULL.
- ovf_cnt, out, OWIDTH, count of packets dropped due to overflow; saturates at all-ones.

Behaviour:
- Pointers are AWIDTH+1 bits with a wrap bit; all pointer arithmetic is modulo 2**(AWIDTH+1).
  - head: next read address.
  - tail: committed end.
  - wr_ptr: next write address.
  - Invariant: head <= tail <= wr_ptr (modular).
- Reset (reset_n=0 at clk edge): head, tail and wr_ptr = 0; bad = 0; ovf_cnt = 0; rd_valid = 0; level = 0; empty = 1; almfull = 0. wr_ready = 1 if proc_mode = 0. rd_data, proc_douta and proc_doutb are don't-care.
- Full condition: full = (wr_ptr - head) == DEPTH. wr_ready = !full & !proc_mode.
- Write path (proc_mode = 0):
  - wr_en & !full & !bad: RAM[wr_ptr] <= wr_data; wr_ptr++.
  - If wr_eop is also set, tail <= wr_ptr+1 in the same cycle, so the packet is readable in the next cycle.
- Overflow:
  - wr_en & full: the word is discarded and bad is set.
  - While bad = 1, words are discarded.
  - On the wr_eop of a bad packet: wr_ptr <= tail; bad <= 0; ovf_cnt++.
- wr_abort: wr_ptr <= tail; bad <= 0. It takes priority over any wr_en in the same cycle (that word is discarded).
- Read path (proc_mode = 0):
  - rd_en & !empty: RAM read at head; head++. Next cycle rd_valid = 1 with rd_data.
  - rd_en & empty: ignored; rd_valid = 0.
- flush: head <= tail (tail value before this cycle's commit). It takes priority over rd_en.
  - Words committed in the same cycle survive the flush.
  - An uncommitted packet is unaffected.
- level = tail - head, registered view of the current pointers. A word committed in cycle N appears in level and empty in cycle N+1.
- Processor mode (proc_mode = 1):
  - RAM port A is driven by proc_addra/proc_dina/proc_wea; port B by proc_addrb.
  - wr_en, rd_en, flush and wr_abort are ignored; all pointers hold; rd_valid = 0.
  - Port outputs are valid 1 cycle after the address. Same-address write/read on A returns the old data (read-first).
- Mode switches take effect on the next clock. The bench waits for rd_valid to drop before entering processor mode.
- Reset asserted mid-packet: all state clears; the partial packet is lost; no ovf_cnt increment.

Decomposition:
- Package fifo_sram_pkg holds the CTRL_W = 8 constant, the pointer-width helper function and the ctrl byte field positions, shared with the controller and the processor tie-in.
- One sub-module, sram_dp_rf: inferred true dual-port, read-first RAM, DWIDTH x 2**AWIDTH, single clock. Its port muxing stays in fifo_sram_pkt.

Test Plan:
- Basic packet: write a 4-word packet 0x1..0x4 with eop on word 4 → empty stays 1 until the cycle after eop, then level = 4; four rd_en pulses return 0x1..0x4 with 1-cycle latency, then empty = 1.
- Abort: write 3 words, assert wr_abort, then write a 2-word packet → level = 2, and reads return only the 2-word packet.
- Overflow (AWIDTH = 4, DEPTH = 16): commit 12 words, then write an 8-word packet → wr_ready drops after 4 words, the packet is dropped at eop, ovf_cnt = 1, wr_ptr == tail, level = 12.
- Wrap-around: stream 40 single-word packets (values 0..39) while reading continuously at DEPTH = 16 → all 40 read in order, no loss, almfull never set with ALM_FULL = 14.
- Flush with simultaneous commit: level = 5, flush in the same cycle as the eop of a 3-word packet → level = 3 next cycle, and reads return the new packet.
- Processor mode: commit a packet, set proc_mode, write 0xAB at address 7, read address 7 on port B → 0xAB one cycle later; wr_en/rd_en ignored; level unchanged after returning to FIFO mode.
